// File: rtl/uart_tx_buffered_if.sv
// Write-side bundle of the buffered UART transmitter.
//   wr_en/wr_data : byte enqueue strobe and data (master -> slave)
//   full/count    : FIFO status (slave -> master)
//   busy/overflow : line activity and sticky dropped-write flag (slave -> master)
interface uart_tx_buffered_if #(
  parameter int FIFO_WIDTH = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic [FIFO_WIDTH:0]   count;
  logic                  busy;
  logic                  overflow;

  modport master (output wr_en, wr_data, input full, count, busy, overflow);
  modport slave  (input wr_en, wr_data, output full, count, busy, overflow);
endinterface

// File: rtl/uart_tx_buffered.sv
// Byte-oriented 8N1 UART transmitter with a write FIFO in front.
//   CLK     : system clock, rising edge
//   reset   : synchronous, active-high
//   wr      : write bus (wr_en, wr_data in; full, count, busy, overflow out)
//   UART_TX : registered serial line, idle high, LSB first
module uart_tx_buffered #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_WIDTH  = 4
) (
  input  logic             CLK,
  input  logic             reset,
  uart_tx_buffered_if.slave wr,
  output logic             UART_TX
);
  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam int BW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BW-1:0]       baud, baud_n;
  logic [2:0]          bit_idx, bit_n;
  logic [7:0]          shift, shift_n;
  logic                tx_n;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_WIDTH:0] cnt;
  logic                ovf;

  logic full, wr_ok, pop, have_data, baud_wrap;

  // full is judged on the pre-edge count, so a pop in the same cycle
  // does not rescue a write attempted while full.
  assign full      = cnt == (FIFO_WIDTH+1)'(DEPTH);
  assign wr_ok     = wr.wr_en && !full;
  assign have_data = cnt != '0;
  assign baud_wrap = baud == BW'(CLK_PER_BIT - 1);

  always_comb begin
    state_n = state;
    baud_n  = baud_wrap ? '0 : baud + BW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = UART_TX;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (have_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: if (baud_wrap) begin
        state_n = DATA;
        bit_n   = 3'd0;
        tx_n    = shift[0];
      end
      DATA: if (baud_wrap) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_n   = bit_idx + 3'd1;
          shift_n = shift >> 1;
          tx_n    = shift[1];
        end
      end
      STOP: if (baud_wrap) begin
        // Chain straight into the next start bit when data is waiting,
        // keeping back-to-back frames gapless.
        if (have_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end else begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      UART_TX <= tx_n;
      if (wr_ok) wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_WIDTH'(1);
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + (FIFO_WIDTH+1)'(1);
        2'b01:   cnt <= cnt - (FIFO_WIDTH+1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr.wr_en && full) ovf <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge CLK) begin
    if (!reset && wr_ok) mem[wr_ptr] <= wr.wr_data;
  end

  assign wr.full     = full;
  assign wr.count    = cnt;
  assign wr.overflow = ovf;
  assign wr.busy     = (state != IDLE) || have_data;
endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;
  localparam int CPB   = 4;
  localparam int FW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DCPB  = 868;

  logic clk = 1'b0;
  logic rst;
  logic tx, tx_d;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.FIFO_WIDTH(FW)) bus ();
  uart_tx_buffered_if #(.FIFO_WIDTH(4))  bus_d ();

  uart_tx_buffered #(.CLK_PER_BIT(CPB), .FIFO_WIDTH(FW)) dut (
    .CLK(clk), .reset(rst), .wr(bus), .UART_TX(tx));

  uart_tx_buffered dut_def (
    .CLK(clk), .reset(rst), .wr(bus_d), .UART_TX(tx_d));

  int ntot = 0;
  int npass = 0;

  // Frame-level reference: a queue of pending bytes plus the position
  // (in clocks) inside the frame currently on the line.
  logic [7:0] q[$];
  bit         m_act = 0;
  int         m_cyc = 0;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 0;

  function automatic logic exp_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_cyc / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic r = 1'b0);
    bit full_pre;
    bus.wr_en = we; bus.wr_data = d; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete(); m_act = 0; m_cyc = 0; m_ovf = 0;
    end else begin
      full_pre = (q.size() == DEPTH);
      if (m_act && m_cyc == FRAME - 1) m_act = 0;
      else if (m_act) m_cyc++;
      if (!m_act && q.size() > 0) begin
        m_cur = q.pop_front(); m_act = 1; m_cyc = 0;
      end
      if (we) begin
        if (!full_pre) q.push_back(d);
        else m_ovf = 1;
      end
    end
    #1;
    chk("tx",       32'(tx),           32'(exp_tx()));
    chk("count",    32'(bus.count),    32'(q.size()));
    chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
    chk("busy",     32'(bus.busy),     32'(m_act || q.size() > 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic idle_until_quiet(input int limit, output int k);
    k = 0;
    do begin
      step(1'b0, 8'h00);
      k++;
    end while (bus.busy && k < limit);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    logic [9:0] frm;
    bus.wr_en = 0; bus.wr_data = 0;
    bus_d.wr_en = 0; bus_d.wr_data = 0;
    rst = 1;

    // reset state
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_def_tx", 32'(tx_d), 32'd1);
    step(1'b0, 8'h00);

    // single byte, latency and busy fall
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    chk("start_latency", 32'(tx), 32'd0);
    idle_until_quiet(80, k);
    chk("busy_fall", 32'(k + 1), 32'd41);

    // back-to-back contiguous frames
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    idle_until_quiet(300, k);
    chk("b2b_len", 32'(k), 32'd119);

    // full / overflow with one frame in flight
    step(1'b1, 8'($urandom));
    repeat (3) step(1'b0, 8'h00);
    repeat (5) step(1'b1, 8'($urandom));
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    idle_until_quiet(400, k);
    chk("ovf_drain", 32'(bus.busy), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // write on the exact edge a STOP ends, with two queued
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    k = 0;
    while (!(m_act && m_cyc == FRAME - 1) && k < 100) begin
      step(1'b0, 8'h00); k++;
    end
    chk("sim_reach", 32'(k < 100), 32'd1);
    chk("sim_pre_count", 32'(bus.count), 32'd2);
    step(1'b1, 8'($urandom));
    chk("sim_count", 32'(bus.count), 32'd2);
    idle_until_quiet(400, k);

    // reset mid-frame during data bit 3 of 0x3C
    step(1'b1, 8'h3C);
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    k = 0;
    while (!(m_act && m_cur == 8'h3C && m_cyc / CPB == 4) && k < 100) begin
      step(1'b0, 8'h00); k++;
    end
    chk("mid_reach", 32'(k < 100), 32'd1);
    step(1'b1, 8'h77, 1'b1);
    chk("mid_tx", 32'(tx), 32'd1);
    chk("mid_count", 32'(bus.count), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    repeat (50) step(1'b0, 8'h00);
    step(1'b1, 8'h81);
    idle_until_quiet(80, k);

    // randomized traffic
    repeat (400) step(($urandom_range(0, 5) == 0), 8'($urandom));
    idle_until_quiet(400, k);

    // default-parameter instance: every bit lasts exactly DCPB cycles
    @(negedge clk);
    bus_d.wr_en = 1; bus_d.wr_data = 8'h41;
    @(posedge clk); #1;
    bus_d.wr_en = 0;
    @(posedge clk); #1;
    frm = {1'b1, 8'h41, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk("def_bit_first", 32'(tx_d), 32'(frm[i]));
      repeat (DCPB - 1) @(posedge clk);
      #1;
      chk("def_bit_last", 32'(tx_d), 32'(frm[i]));
      @(posedge clk); #1;
    end
    chk("def_idle_tx", 32'(tx_d), 32'd1);
    chk("def_idle_busy", 32'(bus_d.busy), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Byte-oriented UART transmitter feeding the board UART_TX pin.
- A FIFO decouples the core's output writes (one cycle each) from serial timing.
- Transmitter counterpart to the loader/input receiver on UART_RX; instantiated inside top_sub and driven by the CPU's output instruction.
- Frame format: 8N1, LSB first, one start bit, one stop bit, no parity.

Parameters:
- CLK_PER_BIT, 868, CLK cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_WIDTH, 4, log2 of FIFO depth (default depth 16).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for wr_data.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds 2^FIFO_WIDTH entries; combinational from registered count.
- count  output  FIFO_WIDTH+1  current FIFO occupancy.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  output  1  sticky flag: a write was attempted while full.
- UART_TX  output  1  serial line, idle high, registered.

Behaviour:
- Reset (reset=1 at an edge), effective after that edge:
  - UART_TX=1, count=0, full=0, busy=0, overflow=0.
  - FSM=IDLE; FIFO pointers zeroed.
  - Reset mid-frame aborts the frame; the line returns high after the reset edge.
  - Reset dominates wr_en in the same cycle.
- Write rules:
  - Accepted when wr_en=1 and full=0 at the edge; wr_data is stored and count increments.
  - Write while full: byte is dropped, count is unchanged, overflow is set and held until reset.
- Pop: the FSM pops the head entry when it starts a frame. A write and a pop in the same cycle leave count unchanged.
- Full uses the pre-edge count. A write while full is dropped even if a pop occurs in that cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TX=1. If count>0, pop the head into the shift register; go to START. UART_TX=0 after that edge.
  - START: hold 0 for CLK_PER_BIT cycles, then go to DATA. Bit index=0; UART_TX=shift[0].
  - DATA: each bit held CLK_PER_BIT cycles. Shift right after each bit. After bit 7 go to STOP; UART_TX=1.
  - STOP: hold 1 for CLK_PER_BIT cycles. At the end:
    - If count>0, pop and enter START directly, so the next start bit follows with no idle gap.
    - Otherwise go to IDLE.
- Counters:
  - Baud counter runs 0..CLK_PER_BIT-1 and wraps, advancing the state or bit on the wrap.
  - Bit counter is 3 bits.
- Frame length is exactly 10*CLK_PER_BIT cycles. Back-to-back frames are contiguous.
- Latency: byte written at edge N into an empty FIFO with FSM in IDLE → start bit visible on UART_TX after edge N+1.
- Pointers wrap modulo 2^FIFO_WIDTH. count distinguishes full from empty.
- busy = (FSM != IDLE) || (count != 0).

Test Plan (CLK_PER_BIT=4, FIFO_WIDTH=2 unless noted):
- Single byte: reset, write 0xA5 at edge N.
  - UART_TX low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - busy falls after edge N+41.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three frames, 120 cycles contiguous, no idle cycle between stop and next start; decoded bytes match in order.
- Full/overflow: hold UART busy, write 5 bytes in 5 cycles (depth 4, 1 popped at the first edge).
  - count reaches 4, full=1, one write dropped, overflow=1.
  - All 4 queued bytes plus the in-flight byte are transmitted intact.
- Simultaneous write/pop: with count=2, write on the exact cycle STOP ends.
  - count stays 2; byte order preserved.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued.
  - UART_TX=1, count=0, busy=0 after the edge; no further frames.
  - A new write of 0x81 afterwards transmits correctly.
- Default parameters: write 0x41 with CLK_PER_BIT=868.
  - Each bit lasts exactly 868 cycles, checked by a UART monitor at 115200 baud.
